// File: rtl/wb_bram_pkg.sv
// wb_bram_pkg: shared types and constants for the two-master Wishbone
// block-RAM arbiter.
//   state_e    : sequencer states (IDLE arbitrates, ACCESS drives the RAM,
//                RESP returns ack/err)
//   WB_DW      : Wishbone data width
//   WB_SW      : Wishbone byte-select width
//   DEF_AW     : default RAM word-address width
//   sat_inc    : saturating increment used for the per-master burst count
package wb_bram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    localparam int WB_DW  = 32;
    localparam int WB_SW  = 4;
    localparam int DEF_AW = 9;

    function automatic logic [3:0] sat_inc(input logic [3:0] val, input logic [3:0] lim);
        return (val >= lim) ? lim : val + 4'd1;
    endfunction

endpackage

// File: rtl/wb_bram_arb_rr_arb2.sv
// rr_arb2: combinational two-way picker.
//   req[1:0]  : per-master request (cyc & stb)
//   last_gnt  : master granted most recently
//   lock_vld  : lock is still live (holder keeps cyc, not forced off)
//   lock_id   : master holding the lock
//   burst_ok  : holder has not yet used up its burst allowance
//   gnt_vld   : some master wins this cycle
//   gnt_id    : winning master
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_gnt,
    input  logic       lock_vld,
    input  logic       lock_id,
    input  logic       burst_ok,
    output logic       gnt_vld,
    output logic       gnt_id
);

    always_comb begin
        gnt_vld = |req;
        gnt_id  = 1'b0;
        if (lock_vld && burst_ok && req[lock_id]) begin
            gnt_id = lock_id;
        end else if (req == 2'b10) begin
            gnt_id = 1'b1;
        end else if (req == 2'b11) begin
            // Tie: the master that did not win last time goes next.
            gnt_id = ~last_gnt;
        end
    end

endmodule

// File: rtl/wb_bram_arb.sv
// wb_bram_arb: shares one single-port 32-bit block RAM between two classic
// Wishbone masters. Round-robin grants with a bounded lock while the holder
// keeps cyc asserted; owns RAM enable/strobes and ack/err generation.
//   sys_clk, rst_n                 : clock, asynchronous active-low reset
//   mN_cyc/stb/we/adr/wdata/sel    : master N request
//   mN_rdata/ack/err               : master N response (rdata only with ack)
//   mem_en/we/addr/wdata           : RAM controls, registered, one cycle
//   mem_rdata                      : RAM read data, valid the cycle after mem_en
//   busy                           : sequencer not in IDLE
module wb_bram_arb
    import wb_bram_pkg::*;
#(
    parameter int AW        = DEF_AW,
    parameter int MAX_BURST = 4
) (
    input  logic             sys_clk,
    input  logic             rst_n,
    input  logic             m0_cyc,
    input  logic             m0_stb,
    input  logic             m0_we,
    input  logic [31:0]      m0_adr,
    input  logic [WB_DW-1:0] m0_wdata,
    input  logic [WB_SW-1:0] m0_sel,
    output logic [WB_DW-1:0] m0_rdata,
    output logic             m0_ack,
    output logic             m0_err,
    input  logic             m1_cyc,
    input  logic             m1_stb,
    input  logic             m1_we,
    input  logic [31:0]      m1_adr,
    input  logic [WB_DW-1:0] m1_wdata,
    input  logic [WB_SW-1:0] m1_sel,
    output logic [WB_DW-1:0] m1_rdata,
    output logic             m1_ack,
    output logic             m1_err,
    output logic             mem_en,
    output logic [WB_SW-1:0] mem_we,
    output logic [AW-1:0]    mem_addr,
    output logic [WB_DW-1:0] mem_wdata,
    input  logic [WB_DW-1:0] mem_rdata,
    output logic             busy
);

    localparam logic [3:0] MAX_B = 4'(MAX_BURST);

    state_e           state_q, state_d;
    logic             gnt_q, gnt_d;
    logic             last_gnt_q, last_gnt_d;
    logic [3:0]       burst_cnt_q, burst_cnt_d;
    logic             lock_vld_q, lock_vld_d;
    logic             mem_en_q, mem_en_d;
    logic [WB_SW-1:0] mem_we_q, mem_we_d;
    logic [AW-1:0]    mem_addr_q, mem_addr_d;
    logic [WB_DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [1:0]       ack_q, ack_d;
    logic [1:0]       err_q, err_d;

    logic [1:0]       req;
    logic             holder_cyc;
    logic             other_req;
    logic             lock_live;
    logic             burst_ok;
    logic             gnt_vld;
    logic             gnt_id;
    logic             continued;
    logic             gnt_cyc;
    logic             range_err;
    logic             win_we;
    logic [31:0]      win_adr;
    logic [WB_DW-1:0] win_wdata;
    logic [WB_SW-1:0] win_sel;

    assign req = {m1_cyc & m1_stb, m0_cyc & m0_stb};

    // The lock holder is always the last granted master. The lock is dropped
    // once its holder lets go of cyc, or when the burst allowance is spent
    // and the other master is waiting.
    assign holder_cyc = last_gnt_q ? m1_cyc : m0_cyc;
    assign other_req  = last_gnt_q ? req[0] : req[1];
    assign lock_live  = lock_vld_q & holder_cyc & ~((burst_cnt_q == MAX_B) & other_req);
    assign burst_ok   = (burst_cnt_q < MAX_B);

    rr_arb2 u_rr_arb2 (
        .req      (req),
        .last_gnt (last_gnt_q),
        .lock_vld (lock_live),
        .lock_id  (last_gnt_q),
        .burst_ok (burst_ok),
        .gnt_vld  (gnt_vld),
        .gnt_id   (gnt_id)
    );

    assign continued = lock_live & (gnt_id == last_gnt_q);
    assign gnt_cyc   = gnt_q ? m1_cyc : m0_cyc;

    assign win_we    = gnt_id ? m1_we    : m0_we;
    assign win_adr   = gnt_id ? m1_adr   : m0_adr;
    assign win_wdata = gnt_id ? m1_wdata : m0_wdata;
    assign win_sel   = gnt_id ? m1_sel   : m0_sel;

    // Any address bit above the RAM window makes the access an error.
    assign range_err = ((win_adr >> (AW + 2)) != 32'd0);

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        last_gnt_d  = last_gnt_q;
        burst_cnt_d = burst_cnt_q;
        lock_vld_d  = lock_vld_q;
        mem_en_d    = 1'b0;
        mem_we_d    = '0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        ack_d       = 2'b00;
        err_d       = 2'b00;

        unique case (state_q)
            ST_IDLE: begin
                lock_vld_d = lock_live;
                if (gnt_vld) begin
                    gnt_d       = gnt_id;
                    last_gnt_d  = gnt_id;
                    lock_vld_d  = 1'b1;
                    burst_cnt_d = continued ? sat_inc(burst_cnt_q, MAX_B) : 4'd1;
                    if (range_err) begin
                        // Error skips the RAM entirely.
                        state_d       = ST_RESP;
                        err_d[gnt_id] = 1'b1;
                    end else begin
                        state_d     = ST_ACCESS;
                        mem_en_d    = 1'b1;
                        mem_we_d    = {WB_SW{win_we}} & win_sel;
                        mem_addr_d  = win_adr[AW+1:2];
                        mem_wdata_d = win_wdata;
                    end
                end
            end
            ST_ACCESS: begin
                state_d = ST_RESP;
                // A master that abandoned its cycle gets no ack; the RAM
                // access already issued this cycle still takes effect.
                if (gnt_cyc) begin
                    ack_d[gnt_q] = 1'b1;
                end else begin
                    lock_vld_d = 1'b0;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            gnt_q       <= 1'b0;
            last_gnt_q  <= 1'b1;
            burst_cnt_q <= 4'd0;
            lock_vld_q  <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            ack_q       <= 2'b00;
            err_q       <= 2'b00;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            last_gnt_q  <= last_gnt_d;
            burst_cnt_q <= burst_cnt_d;
            lock_vld_q  <= lock_vld_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign m0_ack    = ack_q[0];
    assign m1_ack    = ack_q[1];
    assign m0_err    = err_q[0];
    assign m1_err    = err_q[1];
    assign m0_rdata  = ack_q[0] ? mem_rdata : '0;
    assign m1_rdata  = ack_q[1] ? mem_rdata : '0;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_wb_bram_arb.sv
// tb_wb_bram_arb: self-checking bench for wb_bram_arb with a behavioural RAM
// and a word-array reference memory.
module tb_wb_bram_arb;

    localparam int AW   = 9;
    localparam int MAXB = 4;

    logic        sys_clk = 1'b0;
    logic        rst_n;
    logic        m0_cyc, m0_stb, m0_we;
    logic [31:0] m0_adr, m0_wdata;
    logic [3:0]  m0_sel;
    logic [31:0] m0_rdata;
    logic        m0_ack, m0_err;
    logic        m1_cyc, m1_stb, m1_we;
    logic [31:0] m1_adr, m1_wdata;
    logic [3:0]  m1_sel;
    logic [31:0] m1_rdata;
    logic        m1_ack, m1_err;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        busy;

    int checks = 0;
    int failures = 0;

    int            obs_en, obs_ack, obs_err;
    logic          obs_oth;
    logic [3:0]    obs_we;
    logic [AW-1:0] obs_addr;
    logic [31:0]   obs_rd;
    logic [31:0]   refm [0:15];

    always #5 sys_clk = ~sys_clk;

    wb_bram_arb #(.AW(AW), .MAX_BURST(MAXB)) dut (
        .sys_clk(sys_clk), .rst_n(rst_n),
        .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr),
        .m0_wdata(m0_wdata), .m0_sel(m0_sel), .m0_rdata(m0_rdata),
        .m0_ack(m0_ack), .m0_err(m0_err),
        .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr),
        .m1_wdata(m1_wdata), .m1_sel(m1_sel), .m1_rdata(m1_rdata),
        .m1_ack(m1_ack), .m1_err(m1_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    // Single-port RAM with byte enables and one-cycle read latency.
    logic [31:0] ram [0:(1<<AW)-1];
    always @(posedge sys_clk) begin
        if (mem_en) begin
            for (int b = 0; b < 4; b++)
                if (mem_we[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            mem_rdata <= ram[mem_addr];
        end
    end

    task automatic set_m(input int m, input logic cyc, input logic stb, input logic we,
                         input logic [31:0] adr, input logic [31:0] wd, input logic [3:0] sel);
        if (m == 0) begin
            m0_cyc = cyc; m0_stb = stb; m0_we = we; m0_adr = adr; m0_wdata = wd; m0_sel = sel;
        end else begin
            m1_cyc = cyc; m1_stb = stb; m1_we = we; m1_adr = adr; m1_wdata = wd; m1_sel = sel;
        end
    endtask

    task automatic apply_reset();
        @(negedge sys_clk);
        set_m(0, 0, 0, 0, 0, 0, 0);
        set_m(1, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        repeat (2) @(negedge sys_clk);
        rst_n = 1'b1;
        @(negedge sys_clk);
    endtask

    // One classic transaction from master m, starting in an IDLE cycle (cycle 0).
    // Records the cycle offsets of mem_en / ack / err and what was seen.
    task automatic issue(input int m, input logic we, input logic [31:0] adr,
                         input logic [31:0] wd, input logic [3:0] sel);
        obs_en = -1; obs_ack = -1; obs_err = -1; obs_oth = 1'b0;
        obs_we = '0; obs_addr = '0; obs_rd = '0;
        set_m(m, 1, 1, we, adr, wd, sel);
        for (int c = 1; c <= 8; c++) begin
            @(negedge sys_clk);
            if (mem_en && obs_en < 0) begin
                obs_en = c; obs_we = mem_we; obs_addr = mem_addr;
            end
            if (m == 0 ? (m1_ack | m1_err) : (m0_ack | m0_err)) obs_oth = 1'b1;
            if (m == 0 ? m0_ack : m1_ack) begin
                obs_ack = c; obs_rd = (m == 0) ? m0_rdata : m1_rdata;
                break;
            end
            if (m == 0 ? m0_err : m1_err) begin
                obs_err = c;
                break;
            end
        end
        set_m(m, 0, 0, 0, 0, 0, 0);
        @(negedge sys_clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_m(0, 0, 0, 0, 0, 0, 0);
        set_m(1, 0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge sys_clk);
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %0b want 0", busy); end
        checks++;
        if (mem_en !== 1'b0) begin failures++; $display("FAIL reset_mem_en: got %0b want 0", mem_en); end
        checks++;
        if ({m0_ack, m0_err, m1_ack, m1_err} !== 4'b0) begin
            failures++; $display("FAIL reset_ack_err: got %b want 0000", {m0_ack, m0_err, m1_ack, m1_err});
        end
        checks++;
        if ({m0_rdata, m1_rdata, mem_wdata, mem_we, mem_addr} !== '0) begin
            failures++; $display("FAIL reset_data: m0_rdata %0h m1_rdata %0h mem_wdata %0h want 0", m0_rdata, m1_rdata, mem_wdata);
        end
        rst_n = 1'b1;
        @(negedge sys_clk);
    endtask

    task automatic test_write_read();
        issue(0, 1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF);
        checks++;
        if (obs_en !== 1) begin failures++; $display("FAIL wr_mem_en_cycle: got %0d want 1", obs_en); end
        checks++;
        if (obs_ack !== 2) begin failures++; $display("FAIL wr_ack_cycle: got %0d want 2", obs_ack); end
        checks++;
        if (obs_addr !== 9'h004 || obs_we !== 4'hF) begin
            failures++; $display("FAIL wr_mem_ctl: addr %0h we %0h want 4 f", obs_addr, obs_we);
        end
        issue(0, 0, 32'h0000_0010, 32'h0, 4'hF);
        checks++;
        if (obs_ack !== 2) begin failures++; $display("FAIL rd_ack_cycle: got %0d want 2", obs_ack); end
        checks++;
        if (obs_rd !== 32'hDEAD_BEEF) begin failures++; $display("FAIL rd_data: got %0h want deadbeef", obs_rd); end
        checks++;
        if (obs_oth !== 1'b0 || obs_we !== 4'h0) begin
            failures++; $display("FAIL rd_side: m1 resp %0b mem_we %0h want 0 0", obs_oth, obs_we);
        end
    endtask

    task automatic test_byte_write();
        issue(0, 1, 32'h0000_0010, 32'h0000_00AA, 4'h1);
        checks++;
        if (obs_we !== 4'h1) begin failures++; $display("FAIL byte_we: got %0h want 1", obs_we); end
        issue(0, 0, 32'h0000_0010, 32'h0, 4'hF);
        checks++;
        if (obs_rd !== 32'hDEAD_BEAA) begin failures++; $display("FAIL byte_readback: got %0h want deadbeaa", obs_rd); end
    endtask

    task automatic test_error();
        issue(1, 0, 32'h0000_0800, 32'h0, 4'hF);
        checks++;
        if (obs_err !== 1) begin failures++; $display("FAIL err_cycle: got %0d want 1", obs_err); end
        checks++;
        if (obs_en !== -1 || obs_ack !== -1) begin
            failures++; $display("FAIL err_no_access: mem_en cycle %0d ack cycle %0d want -1 -1", obs_en, obs_ack);
        end
    endtask

    task automatic test_abort();
        int   m1_en_c, m0_ack_c, m1_ack_c;
        logic m0_acked_early;
        logic [AW-1:0] m1_addr_seen;
        logic [31:0] rd0;
        m1_en_c = -1; m0_ack_c = -1; m1_ack_c = -1; m0_acked_early = 1'b0;
        m1_addr_seen = '0; rd0 = '0;
        set_m(0, 1, 1, 1, 32'h0000_0020, 32'h1234_5678, 4'hF);
        @(negedge sys_clk);
        checks++;
        if (mem_en !== 1'b1 || mem_addr !== 9'h008) begin
            failures++; $display("FAIL abort_access: mem_en %0b addr %0h want 1 8", mem_en, mem_addr);
        end
        set_m(0, 0, 0, 0, 0, 0, 0);
        set_m(1, 1, 1, 0, 32'h0000_0030, 32'h0, 4'hF);
        @(negedge sys_clk);
        if (m0_ack) m0_acked_early = 1'b1;
        set_m(0, 1, 1, 0, 32'h0000_0020, 32'h0, 4'hF);
        for (int c = 3; c <= 12; c++) begin
            @(negedge sys_clk);
            if (mem_en && m1_en_c < 0 && mem_addr == 9'h00C) begin m1_en_c = c; m1_addr_seen = mem_addr; end
            if (c == 3 && m0_ack) m0_acked_early = 1'b1;
            if (m1_ack) begin m1_ack_c = c; set_m(1, 0, 0, 0, 0, 0, 0); end
            if (m0_ack) begin m0_ack_c = c; rd0 = m0_rdata; set_m(0, 0, 0, 0, 0, 0, 0); break; end
        end
        set_m(0, 0, 0, 0, 0, 0, 0);
        @(negedge sys_clk);
        checks++;
        if (m0_acked_early !== 1'b0) begin failures++; $display("FAIL abort_no_ack: got 1 want 0"); end
        checks++;
        if (m1_en_c !== 4 || m1_ack_c !== 5) begin
            failures++; $display("FAIL abort_m1_next: mem_en cycle %0d ack cycle %0d want 4 5 (addr %0h)", m1_en_c, m1_ack_c, m1_addr_seen);
        end
        checks++;
        if (m0_ack_c !== 8 || rd0 !== 32'h1234_5678) begin
            failures++; $display("FAIL abort_write_landed: ack cycle %0d data %0h want 8 12345678", m0_ack_c, rd0);
        end
    endtask

    task automatic test_burst_lock();
        int n;
        int got [10];
        apply_reset();
        set_m(0, 1, 1, 0, 32'h0000_0040, 32'h0, 4'hF);
        set_m(1, 1, 1, 0, 32'h0000_0044, 32'h0, 4'hF);
        n = 0;
        for (int c = 0; c < 80 && n < 10; c++) begin
            @(negedge sys_clk);
            if (m0_ack && n < 10) begin got[n] = 0; n++; end
            if (m1_ack && n < 10) begin got[n] = 1; n++; end
        end
        set_m(0, 0, 0, 0, 0, 0, 0);
        set_m(1, 0, 0, 0, 0, 0, 0);
        repeat (4) @(negedge sys_clk);
        checks++;
        if (n !== 10) begin failures++; $display("FAIL burst_timeout: grants %0d want 10", n); end
        for (int i = 0; i < n; i++) begin
            checks++;
            if (got[i] !== (i / MAXB) % 2) begin
                failures++; $display("FAIL burst_grant_%0d: got m%0d want m%0d", i, got[i], (i / MAXB) % 2);
            end
        end
    endtask

    task automatic test_back_to_back();
        int n, h0, h1;
        int got [8];
        int t [8];
        apply_reset();
        set_m(0, 1, 1, 0, 32'h0000_0040, 32'h0, 4'hF);
        set_m(1, 1, 1, 0, 32'h0000_0044, 32'h0, 4'hF);
        n = 0; h0 = 0; h1 = 0;
        for (int c = 0; c < 80 && n < 8; c++) begin
            @(negedge sys_clk);
            if (m0_ack) begin
                if (n < 8) begin got[n] = 0; t[n] = c; n++; end
                m0_stb = 1'b0; h0 = 2;
            end else if (h0 > 0) begin
                h0--; if (h0 == 0) m0_stb = 1'b1;
            end
            if (m1_ack) begin
                if (n < 8) begin got[n] = 1; t[n] = c; n++; end
                m1_stb = 1'b0; h1 = 2;
            end else if (h1 > 0) begin
                h1--; if (h1 == 0) m1_stb = 1'b1;
            end
        end
        set_m(0, 0, 0, 0, 0, 0, 0);
        set_m(1, 0, 0, 0, 0, 0, 0);
        repeat (4) @(negedge sys_clk);
        checks++;
        if (n !== 8) begin failures++; $display("FAIL b2b_timeout: grants %0d want 8", n); end
        for (int i = 0; i < n; i++) begin
            checks++;
            if (got[i] !== i % 2) begin
                failures++; $display("FAIL b2b_grant_%0d: got m%0d want m%0d", i, got[i], i % 2);
            end
        end
        if (n == 8) begin
            checks++;
            if (t[7] - t[0] !== 21) begin
                failures++; $display("FAIL b2b_spacing: got %0d cycles want 21", t[7] - t[0]);
            end
        end
    endtask

    task automatic test_reset_in_resp();
        int m0_c, m1_c;
        logic [AW-1:0] first_addr;
        apply_reset();
        set_m(0, 1, 1, 0, 32'h0000_0010, 32'h0, 4'hF);
        repeat (2) @(negedge sys_clk);
        checks++;
        if (m0_ack !== 1'b1) begin failures++; $display("FAIL rstresp_pre_ack: got %0b want 1", m0_ack); end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({m0_ack, busy, mem_en} !== 3'b000 || m0_rdata !== 32'h0) begin
            failures++; $display("FAIL rstresp_forced: ack %0b busy %0b mem_en %0b rdata %0h want 0", m0_ack, busy, mem_en, m0_rdata);
        end
        set_m(0, 0, 0, 0, 0, 0, 0);
        @(negedge sys_clk);
        rst_n = 1'b1;
        @(negedge sys_clk);
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL rstresp_idle: busy %0b want 0", busy); end
        set_m(0, 1, 1, 0, 32'h0000_0010, 32'h0, 4'hF);
        set_m(1, 1, 1, 0, 32'h0000_0014, 32'h0, 4'hF);
        @(negedge sys_clk);
        first_addr = mem_addr;
        checks++;
        if (mem_en !== 1'b1 || first_addr !== 9'h004) begin
            failures++; $display("FAIL rstresp_tie: mem_en %0b addr %0h want 1 4", mem_en, first_addr);
        end
        m0_c = -1; m1_c = -1;
        for (int c = 2; c < 12; c++) begin
            @(negedge sys_clk);
            if (m0_ack) begin m0_c = c; set_m(0, 0, 0, 0, 0, 0, 0); end
            if (m1_ack) begin m1_c = c; set_m(1, 0, 0, 0, 0, 0, 0); end
        end
        checks++;
        if (m0_c !== 2 || m1_c !== 5) begin
            failures++; $display("FAIL rstresp_order: m0 ack %0d m1 ack %0d want 2 5", m0_c, m1_c);
        end
    endtask

    task automatic test_random();
        int          m, idx;
        logic        we, oor;
        logic [31:0] adr, wd;
        logic [3:0]  sel;
        for (int i = 0; i < 16; i++) begin
            wd = $urandom;
            issue(i % 2, 1, 32'(i * 4), wd, 4'hF);
            refm[i] = wd;
            checks++;
            if (obs_ack !== 2) begin failures++; $display("FAIL rnd_init_%0d: ack cycle %0d want 2", i, obs_ack); end
        end
        for (int i = 0; i < 40; i++) begin
            m   = int'($urandom_range(0, 1));
            idx = int'($urandom_range(0, 15));
            we  = 1'($urandom_range(0, 1));
            oor = ($urandom_range(0, 7) == 0);
            sel = 4'($urandom);
            wd  = $urandom;
            adr = 32'(idx * 4) | 32'($urandom_range(0, 3));
            if (oor) adr = adr | (32'($urandom_range(1, 1000)) << (AW + 2));
            issue(m, we, adr, wd, sel);
            if (oor) begin
                checks++;
                if (obs_err !== 1 || obs_en !== -1 || obs_ack !== -1) begin
                    failures++; $display("FAIL rnd_err_%0d: err %0d en %0d ack %0d want 1 -1 -1", i, obs_err, obs_en, obs_ack);
                end
            end else begin
                checks++;
                if (obs_en !== 1 || obs_ack !== 2 || obs_oth !== 1'b0) begin
                    failures++; $display("FAIL rnd_timing_%0d: en %0d ack %0d other %0b want 1 2 0", i, obs_en, obs_ack, obs_oth);
                end
                checks++;
                if (obs_addr !== AW'(idx) || obs_we !== (we ? sel : 4'h0)) begin
                    failures++; $display("FAIL rnd_ctl_%0d: addr %0h we %0h want %0h %0h", i, obs_addr, obs_we, idx, we ? sel : 4'h0);
                end
                if (we) begin
                    for (int b = 0; b < 4; b++)
                        if (sel[b]) refm[idx][8*b +: 8] = wd[8*b +: 8];
                end else begin
                    checks++;
                    if (obs_rd !== refm[idx]) begin
                        failures++; $display("FAIL rnd_rdata_%0d: got %0h want %0h", i, obs_rd, refm[idx]);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byte_write();
        test_error();
        test_abort();
        test_burst_lock();
        test_back_to_back();
        test_reset_in_resp();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
